// File: rtl/cond_exec_stage_if.sv
// Decode-to-execute control bundle and execute-stage results for cond_exec_stage.
// The master drives the decoded controls and reads the conditioned results; the stage is the slave.
interface cond_exec_stage_if #(
    parameter int CNT_W = 16
);
    logic             StallE;
    logic             FlushE;
    logic             PCSrcD;
    logic             RegWD;
    logic             MemWD;
    logic             MemtoRegD;
    logic             BranchD;
    logic [1:0]       FlagWD;
    logic [3:0]       CondD;
    logic             PredTakenD;
    logic [3:0]       ALUFlags;

    logic             PCSrcE;
    logic             RegWE;
    logic             MemWE;
    logic             MemtoRegE;
    logic             BranchTakenE;
    logic             MispredictE;
    logic             CondExE;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] MispredCount;

    modport master (
        output StallE, FlushE, PCSrcD, RegWD, MemWD, MemtoRegD, BranchD,
               FlagWD, CondD, PredTakenD, ALUFlags,
        input  PCSrcE, RegWE, MemWE, MemtoRegE, BranchTakenE, MispredictE,
               CondExE, Flags, MispredCount
    );

    modport slave (
        input  StallE, FlushE, PCSrcD, RegWD, MemWD, MemtoRegD, BranchD,
               FlagWD, CondD, PredTakenD, ALUFlags,
        output PCSrcE, RegWE, MemWE, MemtoRegE, BranchTakenE, MispredictE,
               CondExE, Flags, MispredCount
    );
endinterface

// File: rtl/cond_exec_stage.sv
// Execute stage: D->E control register, NZCV flags, ARM condition check, branch resolution.
// Optional misprediction counter enabled by defining MISPRED_CNT_EN.
module cond_exec_stage #(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    cond_exec_stage_if.slave  bus
);
    logic       ValidE;
    logic       PCSrcE_r;
    logic       RegWE_r;
    logic       MemWE_r;
    logic       MemtoRegE_r;
    logic       BranchE_r;
    logic [1:0] FlagWE_r;
    logic [3:0] CondE_r;
    logic       PredTakenE_r;

    logic [3:0] flags_r;
    logic       cond_result;
    logic       cond_ex;
    logic       pc_src;
    logic       mispredict;

    // Branch type is carried for downstream visibility; resolution uses the PC-write path.
    logic unused_branch;
    assign unused_branch = BranchE_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // A flush loads the same bubble as reset (AL condition, everything else cleared) and beats a stall.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            ValidE       <= 1'b0;
            PCSrcE_r     <= 1'b0;
            RegWE_r      <= 1'b0;
            MemWE_r      <= 1'b0;
            MemtoRegE_r  <= 1'b0;
            BranchE_r    <= 1'b0;
            FlagWE_r     <= 2'b00;
            CondE_r      <= 4'b1110;
            PredTakenE_r <= 1'b0;
        end else if (!bus.StallE) begin
            ValidE       <= 1'b1;
            PCSrcE_r     <= bus.PCSrcD;
            RegWE_r      <= bus.RegWD;
            MemWE_r      <= bus.MemWD;
            MemtoRegE_r  <= bus.MemtoRegD;
            BranchE_r    <= bus.BranchD;
            FlagWE_r     <= bus.FlagWD;
            CondE_r      <= bus.CondD;
            PredTakenE_r <= bus.PredTakenD;
        end
    end

    // Flags survive a flush; the instruction leaving E still commits its flag write.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (!bus.StallE && cond_ex) begin
            if (FlagWE_r[1]) flags_r[3:2] <= bus.ALUFlags[3:2];
            if (FlagWE_r[0]) flags_r[1:0] <= bus.ALUFlags[1:0];
        end
    end

    logic n, z, c, v;
    assign {n, z, c, v} = flags_r;

    // NOTE: the default assignment before the case keeps this purely combinational (no latch).
    always_comb begin
        cond_result = 1'b0;
        case (CondE_r)
            4'b0000: cond_result = z;
            4'b0001: cond_result = !z;
            4'b0010: cond_result = c;
            4'b0011: cond_result = !c;
            4'b0100: cond_result = n;
            4'b0101: cond_result = !n;
            4'b0110: cond_result = v;
            4'b0111: cond_result = !v;
            4'b1000: cond_result = c && !z;
            4'b1001: cond_result = !c || z;
            4'b1010: cond_result = (n == v);
            4'b1011: cond_result = (n != v);
            4'b1100: cond_result = !z && (n == v);
            4'b1101: cond_result = z || (n != v);
            4'b1110: cond_result = 1'b1;
            default: cond_result = 1'b0;
        endcase
    end

    assign cond_ex    = ValidE & cond_result;
    assign pc_src     = PCSrcE_r & cond_ex;
    // A stalled instruction reports its misprediction only in the cycle it actually leaves E.
    assign mispredict = ValidE & !bus.StallE & (pc_src ^ PredTakenE_r);

    assign bus.CondExE      = cond_ex;
    assign bus.PCSrcE       = pc_src;
    assign bus.RegWE        = RegWE_r & cond_ex;
    assign bus.MemWE        = MemWE_r & cond_ex;
    assign bus.MemtoRegE    = MemtoRegE_r;
    assign bus.BranchTakenE = pc_src;
    assign bus.MispredictE  = mispredict;
    assign bus.Flags        = flags_r;

`ifdef MISPRED_CNT_EN
    logic [CNT_W-1:0] mispred_cnt;

    // Saturating count: holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispred_cnt <= '0;
        end else if (mispredict && !(&mispred_cnt)) begin
            mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    assign bus.MispredCount = mispred_cnt;
`else
    assign bus.MispredCount = {CNT_W{1'b0}};
`endif
endmodule
